lsu_wb: RTL
===========

Name: lsu_wb

Overview:
- LSU writeback stage: consumer of the EX/WB state register outputs (is_load, zero_ext, is_nop, size, rd) plus the memory read response.
- Aligns and extends load data per size/offset/zero_ext and drives the LSU register-file write port.
- When memory response lags the load, holds the load context and raises stall to freeze upstream LSU pipeline until data returns.

Parameters:
- REG_ADDR_W, 5, register-file address width (matches rd).
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT (used only with LSU_WB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- is_load_in  in  1  op is a load.
- zero_ext_in  in  1  1 = zero-extend, 0 = sign-extend.
- is_nop_in  in  1  slot is a bubble.
- size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- rd_in  in  REG_ADDR_W  destination register.
- byte_off_in  in  2  load address bits [1:0].
- mem_rvalid  in  1  memory read data valid this cycle.
- mem_rdata  in  32  memory read word (little-endian).
- stall_out  out  1  upstream must hold EX/WB register.
- rf_we  out  1  register write enable.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  32  write data.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (async, any state): state IDLE; rf_we 0, rf_waddr 0, rf_wdata 0, stall_out 0, err_timeout 0, counter 0, captured context cleared.
- Valid load = is_load_in & ~is_nop_in, sampled only when stall_out = 0.
- States: IDLE, WAIT.
- IDLE + valid load + mem_rvalid: rf_we = 1 next cycle (latency 1) with extended data; remain IDLE.
- IDLE + valid load + ~mem_rvalid: capture size, zero_ext, rd, byte_off; go WAIT.
- IDLE + no valid load: rf_we = 0 next cycle. mem_rvalid ignored.
- WAIT: stall_out = 1 (decoded from state register, no combinational path from inputs). Inputs other than mem_rvalid/mem_rdata ignored.
- WAIT + mem_rvalid: write from captured context next cycle; return IDLE.
  - stall_out drops the cycle the write is presented.
  - The upstream op held during the stall is sampled that same cycle.
- Extraction:
  - Byte: mem_rdata[8*byte_off +: 8].
  - Half: mem_rdata[16*byte_off[1] +: 16]; byte_off[0] ignored.
  - Word / 11: full word; byte_off ignored.
- Extension: zero_ext = 1 pads with 0; else replicates extracted MSB to bit 31. zero_ext is ignored for word loads.
- rd = 0: load completes normally (including stall) but rf_we is forced 0.
- rf_we is a single-cycle pulse per load. rf_waddr/rf_wdata hold their last values when rf_we = 0.
- Non-load ops (stores, other) never write.

Optional Feature:
- Macro LSU_WB_TIMEOUT_EN.
- Defined:
  - Counter increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without mem_rvalid: set err_timeout (sticky until rst), return IDLE, no write, stall_out 0.
  - mem_rvalid on the limit cycle wins: normal write, no error.
- Undefined: no counter; WAIT persists indefinitely; err_timeout tied 0.

Test Plan:
- lb, zero_ext = 0, off = 0, mem_rdata = 0x00000080, rvalid same cycle, rd = 5 -> next cycle rf_we = 1, waddr 5, wdata 0xFFFFFF80, stall_out never high.
- lhu, off = 2, mem_rdata = 0xBEEF1234, rd = 7 -> wdata 0x0000BEEF; same with lh -> 0xFFFFBEEF; lbu off = 3 -> 0x000000BE.
- lw rd = 9, rvalid 3 cycles late with 0xCAFEF00D; different op on inputs during wait -> stall_out high 3 cycles, single write 0xCAFEF00D to r9 one cycle after rvalid, next op accepted cleanly.
- lw rd = 0 with rvalid; nop with rvalid; store with rvalid -> rf_we stays 0 throughout.
- Load enters WAIT, rst pulsed mid-wait, late rvalid arrives -> all outputs 0, no write, state IDLE.
- With LSU_WB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no rvalid -> err_timeout set after 4 WAIT cycles, stall_out released, no write; err_timeout held until rst.

Source files
------------

// File: rtl/lsu_wb_if.sv
// lsu_wb_if: EX/WB load context, memory read response and register-file write port of the LSU writeback stage
interface lsu_wb_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  is_load_in;
  logic                  zero_ext_in;
  logic                  is_nop_in;
  logic [1:0]            size_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic [1:0]            byte_off_in;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic                  stall_out;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [31:0]           rf_wdata;
  logic                  err_timeout;
  modport master (
    output is_load_in, zero_ext_in, is_nop_in, size_in, rd_in, byte_off_in, mem_rvalid, mem_rdata,
    input  stall_out, rf_we, rf_waddr, rf_wdata, err_timeout
  );
  modport slave (
    input  is_load_in, zero_ext_in, is_nop_in, size_in, rd_in, byte_off_in, mem_rvalid, mem_rdata,
    output stall_out, rf_we, rf_waddr, rf_wdata, err_timeout
  );
endinterface

// File: rtl/lsu_wb.sv
// lsu_wb: LSU writeback stage aligning/extending load data, stalling upstream on late memory data (optional WAIT watchdog via LSU_WB_TIMEOUT_EN)
module lsu_wb #(
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic     clk,
  input logic     rst,
  lsu_wb_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                state;
  logic [1:0]            c_size, c_off;
  logic                  c_zext;
  logic [REG_ADDR_W-1:0] c_rd;
  logic                  held, load_ok, fire;
  logic [1:0]            w_size, w_off;
  logic                  w_zext;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [31:0]           w_data;
  if (TIMEOUT_CYCLES < 1) begin : g_chk
    $error("lsu_wb: TIMEOUT_CYCLES must be at least 1");
  end
`ifdef LSU_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  assign bus.err_timeout = 1'b0;
`endif
  function automatic logic [31:0] extend(input logic [1:0] size, input logic [1:0] off, input logic zext, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    return size == 2'b00 ? {{24{~zext & b[7]}}, b} : size == 2'b01 ? {{16{~zext & h[15]}}, h} : d;
  endfunction
  // Write context comes from the captured load while waiting, else straight from the EX/WB register
  always_comb begin
    held    = state == WAIT;
    load_ok = bus.is_load_in & ~bus.is_nop_in;
    w_size  = held ? c_size : bus.size_in;
    w_off   = held ? c_off : bus.byte_off_in;
    w_zext  = held ? c_zext : bus.zero_ext_in;
    w_rd    = held ? c_rd : bus.rd_in;
    w_data  = extend(w_size, w_off, w_zext, bus.mem_rdata);
    fire    = bus.mem_rvalid & (held | load_ok);
  end
  // FSM: write back on data arrival, capture and stall when the response lags the load
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      bus.stall_out <= 1'b0;
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      c_size        <= '0;
      c_off         <= '0;
      c_zext        <= 1'b0;
      c_rd          <= '0;
`ifdef LSU_WB_TIMEOUT_EN
      cnt             <= '0;
      bus.err_timeout <= 1'b0;
`endif
    end else begin
      bus.rf_we <= fire & (w_rd != '0);
      if (fire && w_rd != '0) begin
        bus.rf_waddr <= w_rd;
        bus.rf_wdata <= w_data;
      end
      if (!held && load_ok && !bus.mem_rvalid) begin
        state         <= WAIT;
        bus.stall_out <= 1'b1;
        c_size        <= bus.size_in;
        c_off         <= bus.byte_off_in;
        c_zext        <= bus.zero_ext_in;
        c_rd          <= bus.rd_in;
      end
      if (held && bus.mem_rvalid) begin
        state         <= IDLE;
        bus.stall_out <= 1'b0;
      end
`ifdef LSU_WB_TIMEOUT_EN
      cnt <= held && !bus.mem_rvalid ? cnt + 1'b1 : '0;
      if (held && !bus.mem_rvalid && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state           <= IDLE;
        bus.stall_out   <= 1'b0;
        bus.err_timeout <= 1'b1;
        cnt             <= '0;
      end
`endif
    end
endmodule
